// File: rtl/ps2_event_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_event_sequencer
// Purpose  : Turns PS/2 scan-code bytes into key events, tracks shift and
//            caps-lock state, and buffers the events in a valid/ready FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_event_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic [7:0] evt_code,
    output logic       evt_release,
    output logic       evt_extended,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       shift,
    output logic       caps_lock,
    output logic       overflow,
    input  logic       clear_ovf
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GOT_E0   = 2'd1,
        S_GOT_F0   = 2'd2,
        S_GOT_E0F0 = 2'd3
    } state_t;

    localparam logic [7:0]    c_PFX_E0  = 8'hE0;
    localparam logic [7:0]    c_PFX_F0  = 8'hF0;
    localparam logic [7:0]    c_SHIFT_L = 8'h12;
    localparam logic [7:0]    c_SHIFT_R = 8'h59;
    localparam logic [7:0]    c_CAPS    = 8'h58;
    localparam logic [ADDR_W:0] c_FULL  = (ADDR_W + 1)'(FIFO_DEPTH);

    state_t r_state, w_state_nxt;
    logic   w_evt, w_evt_rel, w_evt_ext, w_nonkey;

    logic [9:0]        r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_full, w_pop, w_push;
    logic              r_shift_l, r_shift_r, r_caps_lock, r_caps_held, r_overflow;

    always_comb begin
        w_nonkey = 1'b0;
        case (rx_data)
            8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF: w_nonkey = 1'b1;
            default:                                  w_nonkey = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Prefix decoder: rx_error and non-key bytes both abandon any partial prefix
    always_comb begin
        w_state_nxt = r_state;
        w_evt       = 1'b0;
        w_evt_rel   = 1'b0;
        w_evt_ext   = 1'b0;
        if (rx_error) begin
            w_state_nxt = S_IDLE;
        end else if (rx_valid) begin
            if (w_nonkey) begin
                w_state_nxt = S_IDLE;
            end else if (rx_data == c_PFX_E0) begin
                w_state_nxt = (r_state == S_GOT_E0F0) ? S_GOT_E0F0 : S_GOT_E0;
            end else if (rx_data == c_PFX_F0) begin
                case (r_state)
                    S_IDLE:  w_state_nxt = S_GOT_F0;
                    S_GOT_F0: w_state_nxt = S_GOT_F0;
                    default: w_state_nxt = S_GOT_E0F0;
                endcase
            end else begin
                w_state_nxt = S_IDLE;
                w_evt       = 1'b1;
                w_evt_rel   = (r_state == S_GOT_F0) || (r_state == S_GOT_E0F0);
                w_evt_ext   = (r_state == S_GOT_E0) || (r_state == S_GOT_E0F0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift_l   <= 1'b0;
            r_shift_r   <= 1'b0;
            r_caps_lock <= 1'b0;
            r_caps_held <= 1'b0;
        end else if (w_evt && !w_evt_ext) begin
            if (rx_data == c_SHIFT_L) r_shift_l <= !w_evt_rel;
            if (rx_data == c_SHIFT_R) r_shift_r <= !w_evt_rel;
            if (rx_data == c_CAPS) begin
                // Typematic repeats arrive as further makes; only the first toggles
                if (!w_evt_rel) begin
                    if (!r_caps_held) r_caps_lock <= !r_caps_lock;
                    r_caps_held <= 1'b1;
                end else begin
                    r_caps_held <= 1'b0;
                end
            end
        end
    end

    assign w_full = (r_count == c_FULL);
    assign w_pop  = evt_valid && evt_ready;
    assign w_push = w_evt && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {rx_data, w_evt_rel, w_evt_ext};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_evt && !w_push) r_overflow <= 1'b1;
            else if (clear_ovf)   r_overflow <= 1'b0;
        end
    end

    assign evt_code     = r_mem[r_rd_ptr][9:2];
    assign evt_release  = r_mem[r_rd_ptr][1];
    assign evt_extended = r_mem[r_rd_ptr][0];
    assign evt_valid    = (r_count != '0);
    assign shift        = r_shift_l || r_shift_r;
    assign caps_lock    = r_caps_lock;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_event_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_event_sequencer
// Purpose  : Directed self-checking bench for ps2_event_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_event_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, rx_valid, rx_error, evt_ready, clear_ovf;
    logic [7:0] rx_data;
    logic [7:0] evt_code;
    logic       evt_release, evt_extended, evt_valid, shift, caps_lock, overflow;

    int n_checks = 0;
    int n_errors = 0;

    ps2_event_sequencer #(.FIFO_DEPTH(8), .ADDR_W(3)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_error     (rx_error),
        .evt_code     (evt_code),
        .evt_release  (evt_release),
        .evt_extended (evt_extended),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .shift        (shift),
        .caps_lock    (caps_lock),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte is captured on the posedge between the two negedges
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expect_evt(input string tag, input logic [7:0] code, input logic rel, input logic ext);
        check({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check({tag, "_code"},  32'(evt_code),  32'(code));
        check({tag, "_rel"},   32'(evt_release), 32'(rel));
        check({tag, "_ext"},   32'(evt_extended), 32'(ext));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
        evt_ready = 1'b0; clear_ovf = 1'b0;
        do_reset();

        check("rst_valid",   32'(evt_valid), 32'd0);
        check("rst_code",    32'(evt_code), 32'd0);
        check("rst_rel",     32'(evt_release), 32'd0);
        check("rst_ext",     32'(evt_extended), 32'd0);
        check("rst_shift",   32'(shift), 32'd0);
        check("rst_caps",    32'(caps_lock), 32'd0);
        check("rst_ovf",     32'(overflow), 32'd0);

        // Plain make / break
        evt_ready = 1'b1;
        send_byte(8'h1C);
        expect_evt("make1c", 8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        check("make1c_pulse", 32'(evt_valid), 32'd0);
        send_byte(8'hF0);
        check("f0_noevt", 32'(evt_valid), 32'd0);
        send_byte(8'h1C);
        expect_evt("brk1c", 8'h1C, 1'b1, 1'b0);
        @(negedge clk);
        check("brk1c_pulse", 32'(evt_valid), 32'd0);

        // Extended make / break
        send_byte(8'hE0);
        send_byte(8'h75);
        expect_evt("emake75", 8'h75, 1'b0, 1'b1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        check("e0f0_noevt", 32'(evt_valid), 32'd0);
        send_byte(8'h75);
        expect_evt("ebrk75", 8'h75, 1'b1, 1'b1);
        check("ext_shift", 32'(shift), 32'd0);

        // Modifiers and caps-lock typematic
        send_byte(8'h12);  check("shift_make", 32'(shift), 32'd1);
        send_byte(8'h58);  check("caps_1st", 32'(caps_lock), 32'd1);
        send_byte(8'h58);  check("caps_rep1", 32'(caps_lock), 32'd1);
        send_byte(8'h58);  check("caps_rep2", 32'(caps_lock), 32'd1);
        send_byte(8'hF0);
        send_byte(8'h58);  check("caps_brk", 32'(caps_lock), 32'd1);
        expect_evt("caps_brk_evt", 8'h58, 1'b1, 1'b0);
        send_byte(8'h58);  check("caps_2nd", 32'(caps_lock), 32'd0);
        check("shift_held", 32'(shift), 32'd1);
        send_byte(8'hF0);
        send_byte(8'h12);  check("shift_brk", 32'(shift), 32'd0);
        @(negedge clk);

        // Overflow: nine makes into an eight-entry FIFO
        evt_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        check("ovf_set", 32'(overflow), 32'd1);
        evt_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", 32'(evt_valid), 32'd1);
            check("drain_code", 32'(evt_code), 32'(i));
            @(negedge clk);
        end
        check("drain_empty", 32'(evt_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);

        // Error recovery and non-key bytes
        send_byte(8'hF0);
        @(negedge clk);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        send_byte(8'h1C);
        expect_evt("err_recover", 8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        check("err_single", 32'(evt_valid), 32'd0);
        send_byte(8'hAA);  check("aa_noevt", 32'(evt_valid), 32'd0);
        send_byte(8'hFA);  check("fa_noevt", 32'(evt_valid), 32'd0);
        @(negedge clk);
        rx_error = 1'b1; rx_data = 8'h2B; rx_valid = 1'b1;
        @(negedge clk);
        rx_error = 1'b0; rx_valid = 1'b0;
        check("err_wins", 32'(evt_valid), 32'd0);

        // Full FIFO with simultaneous pop and push
        evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'h21 + 8'(i));
        check("full_noovf", 32'(overflow), 32'd0);
        evt_ready = 1'b1; rx_data = 8'h30; rx_valid = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0; rx_valid = 1'b0;
        check("pp_noovf", 32'(overflow), 32'd0);
        check("pp_head", 32'(evt_code), 32'h22);
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("pp_valid", 32'(evt_valid), 32'd1);
            check("pp_code", 32'(evt_code), (i < 7) ? 32'h22 + 32'(i) : 32'h30);
            @(negedge clk);
        end
        check("pp_empty", 32'(evt_valid), 32'd0);

        // Reset mid-sequence drops the pending E0 prefix
        send_byte(8'hE0);
        do_reset();
        send_byte(8'h1C);
        expect_evt("rst_mid", 8'h1C, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_event_sequencer.md
# ps2_event_sequencer

Sequences raw PS/2 scan-code bytes into complete key events for the keyboard FPGA, sitting between the PS/2 byte receiver and the message decoder / CPU interface. Runs the E0/F0 prefix state machine, tracks shift and caps-lock state, and buffers completed events in a small FIFO with a valid/ready handshake. The downstream consumer can stall without losing keystrokes; overflow is flagged.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2
- ADDR_W, 3, log2(FIFO_DEPTH)

- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_data  in  8  byte from PS/2 receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_error  in  1  one-cycle strobe, parity/framing error on current byte
- evt_code  out  8  scan code of FIFO head event
- evt_release  out  1  head event is a break (F0-prefixed)
- evt_extended  out  1  head event is extended (E0-prefixed)
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- shift  out  1  left or right shift currently held
- caps_lock  out  1  caps-lock toggle state
- overflow  out  1  sticky: event dropped because FIFO full
- clear_ovf  in  1  clears overflow

## Operation
- Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Advances only on rx_valid.
  - IDLE: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; other code byte -> push {code, rel=0, ext=0}, stay.
  - GOT_E0: 0xF0 -> GOT_E0F0; 0xE0 -> stay; code -> push {code,0,1}, IDLE.
  - GOT_F0: 0xF0 -> stay; 0xE0 -> GOT_E0 (violation, restart); code -> push {code,1,0}, IDLE.
  - GOT_E0F0: 0xE0/0xF0 -> stay; code -> push {code,1,1}, IDLE.
- Non-key bytes 0x00, 0xAA, 0xE1, 0xFA, 0xFE, 0xFF: discarded in any state, FSM -> IDLE, no push.
- rx_error: FSM -> IDLE, byte discarded, no push; rx_error wins over simultaneous rx_valid.
- Modifiers (non-extended codes only): 0x12 = left shift, 0x59 = right shift; make sets, break clears its own flag; shift = L|R.
- Caps lock (0x58, non-extended): make toggles caps_lock only if caps_held=0, then sets caps_held; break clears caps_held (typematic repeats do not retoggle).
- All completed key events, including modifiers, are pushed.
- FIFO: push if not full; if full and no simultaneous pop, event dropped, overflow <= 1. Push and pop same cycle when full: both accepted, count unchanged. Pointers wrap modulo FIFO_DEPTH; count width ADDR_W+1.
- overflow: set wins over clear_ovf in same cycle.

## Timing
- Reset (rst_n=0 at clk edge): FSM IDLE, pointers/count 0, evt_valid=0, evt_code=0, evt_release=0, evt_extended=0, shift=0, caps_lock=0, caps_held=0, overflow=0. Reset mid-sequence discards partial prefix and all buffered events.
- Final byte with rx_valid at edge N: evt_valid=1 at N+1 when FIFO was empty; shift/caps_lock updated at N+1.
- Pop at edge M (evt_valid & evt_ready): next entry presented at M+1; evt_valid drops at M+1 if that was the last entry.
- evt_code/evt_release/evt_extended stable while evt_valid=1 and no pop; don't-care (hold last) when evt_valid=0.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset then bytes 0x1C; 0xF0,0x1C with evt_ready=1 -> events {0x1C,0,0} then {0x1C,1,0}, evt_valid pulses one cycle each.
- 0xE0,0x75; 0xE0,0xF0,0x75 -> {0x75,0,1} then {0x75,1,1}; shift stays 0.
- 0x12, 0x58, 0x58, 0x58, 0xF0,0x58, 0x58, 0xF0,0x12 -> shift 1 then 0 after last break; caps_lock 1 after first make, stays 1 through repeats, 0 after second press.
- evt_ready=0, send 9 make codes 0x01..0x09 -> count 8, overflow=1, drain yields 0x01..0x08 in order; clear_ovf -> overflow=0.
- 0xF0 then rx_error, then 0x1C -> single event {0x1C,0,0}; 0xAA and 0xFA -> no event.
- FIFO full, evt_ready=1 with concurrent new event -> no overflow, count remains 8, new event emerges last.
